// File: rtl/sort4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sort4_pkg
// Description : Shared definitions for the four-entry batch sorter: default
//               batch size and entry width, and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sort4_pkg;

    // Default batch size (entries per batch) and entry width in bits.
    localparam int SORT4_N = 4;
    localparam int SORT4_W = 4;

    // Controller states. The controller holds its state in a plain 2-bit
    // vector and mirrors these values as localparams.
    typedef enum logic [1:0] {
        S4_IDLE = 2'd0,
        S4_LOAD = 2'd1,
        S4_SORT = 2'd2,
        S4_OUT  = 2'd3
    } sort4_state_e;

endpackage : sort4_pkg
`default_nettype wire

// File: rtl/mag_cmp4.sv
`default_nettype none
// ============================================================================
// Module      : mag_cmp4
// Description : Unsigned W-bit magnitude comparator. Exactly one of gt/eq/lt
//               is high for any input pair.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   a   in  W  left operand
//   b   in  W  right operand
//   gt  out 1  a >  b
//   eq  out 1  a == b
//   lt  out 1  a <  b
// ============================================================================
module mag_cmp4 #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         eq,
    output logic         lt
);

    always_comb begin
        gt = 1'b0;
        eq = 1'b0;
        lt = 1'b0;
        if (a > b) begin
            gt = 1'b1;
        end else if (a == b) begin
            eq = 1'b1;
        end else begin
            lt = 1'b1;
        end
    end

endmodule : mag_cmp4
`default_nettype wire

// File: rtl/sort4_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sort4_ctrl
// Description : Batch sorter. Accepts N words over a valid/ready input,
//               bubble-sorts them in place (one compare per cycle through a
//               single shared comparator), then streams them out over a
//               valid/ready output with a last-word marker.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in  1  rising-edge clock
//   rst        in  1  synchronous active-high reset
//   desc       in  1  sort order (1 = descending), sampled on first word
//   in_valid   in  1  input word valid
//   in_data    in  W  input word
//   in_ready   out 1  block accepts in_data this cycle
//   out_valid  out 1  out_data valid
//   out_data   out W  sorted word
//   out_last   out 1  final word of the batch
//   out_ready  in  1  consumer accepts out_data
//   busy       out 1  controller not idle
// ============================================================================
module sort4_ctrl
    import sort4_pkg::*;
#(
    parameter int N = SORT4_N,
    parameter int W = SORT4_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         desc,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy
);

    localparam int IDX_W = $clog2(N);

    localparam logic [1:0] ST_IDLE = 2'(S4_IDLE);
    localparam logic [1:0] ST_LOAD = 2'(S4_LOAD);
    localparam logic [1:0] ST_SORT = 2'(S4_SORT);
    localparam logic [1:0] ST_OUT  = 2'(S4_OUT);

    localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] C_PASS_LAST = IDX_W'(N - 2);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_pass;
    logic [IDX_W-1:0] r_j;
    logic             r_desc;
    logic [W-1:0]     r_buf [N];

    logic [IDX_W-1:0] w_j1;
    logic [IDX_W-1:0] w_j_end;
    logic [W-1:0]     w_a;
    logic [W-1:0]     w_b;
    logic             w_gt;
    logic             w_eq;
    logic             w_lt;
    logic             w_swap;
    logic             w_in_fire;
    logic             w_out_fire;

    // ------------------------------------------------------------------
    // Shared comparator: always looks at the adjacent pair (j, j+1).
    // ------------------------------------------------------------------
    assign w_j1    = r_j + 1'b1;
    assign w_j_end = C_PASS_LAST - r_pass;
    assign w_a     = r_buf[r_j];
    assign w_b     = r_buf[w_j1];

    mag_cmp4 #(
        .W (W)
    ) u_cmp (
        .a  (w_a),
        .b  (w_b),
        .gt (w_gt),
        .eq (w_eq),
        .lt (w_lt)
    );

    // Equal entries never swap, which keeps the sort stable.
    assign w_swap = ~w_eq & (r_desc ? w_lt : w_gt);

    // ------------------------------------------------------------------
    // Handshakes and outputs
    // ------------------------------------------------------------------
    assign in_ready   = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign out_valid  = (r_state == ST_OUT);
    assign busy       = (r_state != ST_IDLE);
    assign w_in_fire  = in_ready & in_valid;
    assign w_out_fire = out_valid & out_ready;

    // Gated so that idle/load/sort cycles present zero rather than stale data.
    assign out_data = out_valid ? r_buf[r_idx] : '0;
    assign out_last = out_valid && (r_idx == C_IDX_LAST);

    // ------------------------------------------------------------------
    // Sequencing FSM, counters and buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_pass  <= '0;
            r_j     <= '0;
            r_desc  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_fire) begin
                        r_buf[0] <= in_data;
                        r_desc   <= desc;
                        r_idx    <= IDX_W'(1);
                        r_state  <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (w_in_fire) begin
                        r_buf[r_idx] <= in_data;
                        if (r_idx == C_IDX_LAST) begin
                            r_idx   <= '0;
                            r_pass  <= '0;
                            r_j     <= '0;
                            r_state <= ST_SORT;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end

                ST_SORT: begin
                    if (w_swap) begin
                        r_buf[r_j] <= w_b;
                        r_buf[w_j1] <= w_a;
                    end
                    // Pass p ends when j reaches N-2-p; the final pass has
                    // a single compare at j = 0.
                    if (r_j == w_j_end) begin
                        r_j <= '0;
                        if (r_pass == C_PASS_LAST) begin
                            r_pass  <= '0;
                            r_idx   <= '0;
                            r_state <= ST_OUT;
                        end else begin
                            r_pass <= r_pass + 1'b1;
                        end
                    end else begin
                        r_j <= w_j1;
                    end
                end

                ST_OUT: begin
                    if (w_out_fire) begin
                        if (r_idx == C_IDX_LAST) begin
                            r_idx   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

endmodule : sort4_ctrl
`default_nettype wire

// File: tb/tb_sort4_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort4_ctrl
// Description : Scoreboard bench for sort4_ctrl. Stimulus pushes hand-computed
//               expected output words (with source-position tags) into a
//               queue; a monitor pops and compares on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sort4_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       desc = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_last;
    logic       out_ready = 1'b1;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] data;
        logic       last;
        int         tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    sort4_ctrl #(
        .N (4),
        .W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .desc      (desc),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every output handshake pops one expected word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got data %0h last %0b, required no output", out_data, out_last);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_data !== e.data || out_last !== e.last) begin
                    n_fail++;
                    $display("FAIL out_word(tag %0d): got data %0h last %0b, required data %0h last %0b",
                             e.tag, out_data, out_last, e.data, e.last);
                end
            end
        end
    end

    // mode 0: normal, 1: stall out_ready at idx 1 with in_valid pulses,
    // 2: reset during SORT cycle 3 (batch discarded).
    task automatic run_batch(input logic [15:0] words, input logic d,
                             input logic [15:0] exp_w, input logic [7:0] tags,
                             input int mode, input string name);
        int n;
        if (mode != 2) begin
            for (int i = 0; i < 4; i++) begin
                exp_t e;
                e.data = exp_w[i*4 +: 4];
                e.last = (i == 3);
                e.tag  = int'(tags[i*2 +: 2]);
                sb.push_back(e);
            end
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = words[i*4 +: 4];
            desc     = (i == 0) ? d : ~d;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        desc     = 1'b0;
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) check({name, "_sort_in_ready_busy"}, {in_ready, busy}, 2'b01);
            if (mode == 2 && c == 3) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check({name, "_rst_idle"}, {busy, out_valid, in_ready}, 3'b001);
                check({name, "_rst_no_pending"}, sb.size(), 0);
                return;
            end
            if (out_valid) begin
                n = c;
                break;
            end
        end
        check({name, "_latency"}, n, 7);
        if (mode == 1) begin
            @(posedge clk); #1;
            out_ready = 1'b0;
            for (int h = 0; h < 3; h++) begin
                in_valid = 1'b1;
                in_data  = 4'h7;
                @(negedge clk);
                check({name, "_hold_data_last"}, {out_valid, out_last, out_data}, {2'b10, exp_w[7:4]});
                check({name, "_hold_in_ready"}, in_ready, 1'b0);
                @(posedge clk); #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                n = 1;
                break;
            end
        end
        check({name, "_drained"}, n, 1);
        check({name, "_idle_after"}, {busy, in_ready}, 2'b01);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_last", out_last, 1'b0);
        check("reset_out_data", out_data, 4'h0);
        check("reset_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 9,3,F,0 ascending -> 0,3,9,F
        run_batch(16'h0F39, 1'b0, 16'hF930, 8'h87, 0, "asc");
        // 9,3,F,0 descending -> F,9,3,0
        run_batch(16'h0F39, 1'b1, 16'h039F, 8'hD2, 0, "desc");
        // 5,5,2,5 ascending -> 2,5(t0),5(t1),5(t3)
        run_batch(16'h5255, 1'b0, 16'h5552, 8'hD2, 0, "equal");
        // Output stall at idx 1 with ignored input pulses
        run_batch(16'h0F39, 1'b0, 16'hF930, 8'h87, 1, "stall");
        // Reset during sort discards the batch
        run_batch(16'h0F39, 1'b0, 16'hF930, 8'h87, 2, "abort");
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_output", sb.size(), 0);
        // Post-reset batch 1,0,0,0 -> 0,0,0,1
        run_batch(16'h0001, 1'b0, 16'h1000, 8'h39, 0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_sort4_ctrl
`default_nettype wire

// File: doc/sort4_ctrl.md
SORT4_CTRL -- requirements
Module: sort4_ctrl

Interface
REQ-001 SHALL provide parameter N, default 4, meaning number of entries per batch (fixed 4 this revision).
REQ-002 SHALL provide parameter W, default 4, meaning entry width in bits.
REQ-003 SHALL use one clock; reset is synchronous and active-high: port clk, input, 1, rising-edge clock.
REQ-004 SHALL provide rst, input, 1, synchronous active-high reset.
REQ-005 SHALL provide desc, input, 1, sort order (1 = descending); sampled when the first word of a batch is accepted.
REQ-006 SHALL provide in_valid, input, 1, input word valid.
REQ-007 SHALL provide in_data, input, W, input word.
REQ-008 SHALL provide in_ready, output, 1, block accepts in_data this cycle.
REQ-009 SHALL provide out_valid, output, 1, out_data valid.
REQ-010 SHALL provide out_data, output, W, sorted word.
REQ-011 SHALL provide out_last, output, 1, marks final word of batch.
REQ-012 SHALL provide out_ready, input, 1, consumer accepts out_data.
REQ-013 SHALL provide busy, output, 1, high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, LOAD, SORT, OUT.
REQ-015 IDLE: in_ready=1; on in_valid, SHALL write in_data to buf[0], latch desc, set idx=1, and go to LOAD.
REQ-016 LOAD: in_ready=1; each accepted word SHALL be written to buf[idx] and idx incremented; acceptance of word N-1 SHALL move to SORT.
REQ-017 in_ready SHALL be 0 in SORT and OUT; in_valid there SHALL be ignored with no state change.
REQ-018 SORT SHALL run bubble passes p=0..N-2, j=0..N-2-p, one comparison per cycle, exactly N(N-1)/2 = 6 cycles.
REQ-019 Each SORT cycle SHALL compare buf[j] against buf[j+1] through the single shared comparator instance.
REQ-020 Swap SHALL occur in the same cycle iff (desc=0 and greater) or (desc=1 and less); equal SHALL never swap.
REQ-021 After the last comparison, the state SHALL go to OUT with idx=0.
REQ-022 Latency: last input accepted on edge k; SORT occupies cycles k+1..k+6; out_valid first high in cycle k+7.
REQ-023 OUT: out_valid=1 and out_data=buf[idx].
REQ-024 out_last SHALL be 1 iff idx=N-1.
REQ-025 In OUT, out_data and out_last SHALL hold stable while out_ready=0.
REQ-026 In OUT, each out_valid&out_ready handshake SHALL increment idx; the handshake on idx=N-1 SHALL return to IDLE.
REQ-027 A new batch SHALL be accepted in the cycle after the IDLE return; there is no back-to-back overlap.
REQ-028 All arithmetic is unsigned W-bit; idx is clog2(N) bits and SHALL never wrap past N-1.

Reset
REQ-029 rst=1 SHALL force state IDLE, idx=0, all buf entries 0, and latched desc 0 on the next clk edge.
REQ-030 Reset values SHALL be in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0.
REQ-031 rst asserted mid-LOAD, SORT or OUT SHALL discard the batch; no partial output SHALL be emitted afterwards.
REQ-032 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-033 Package sort4_pkg SHALL hold the state enum typedef and the N and W default constants.
REQ-034 The design SHALL contain exactly one sub-module instance, mag_cmp4 (W-bit magnitude comparator; outputs gt, eq, lt, exactly one high).
REQ-035 The sequencing FSM, index counters and buffer SHALL reside in sort4_ctrl; no second comparator is allowed.

Verification
REQ-036 Load 9,3,F,0 with desc=0 -> out 0,3,9,F; out_last on F; first out_valid exactly 7 cycles after the last accept.
REQ-037 Load 9,3,F,0 with desc=1 -> out F,9,3,0.
REQ-038 Load 5,5,2,5 with desc=0 -> out 2,5,5,5; the three 5s keep their input order (tag via scoreboard).
REQ-039 Hold out_ready=0 for 3 cycles at idx=1 -> out_data stable; sequence completes unchanged; in_valid pulses during OUT are ignored.
REQ-040 Assert rst during SORT cycle 3 -> next cycle IDLE, out_valid=0, in_ready=1; a following batch 1,0,0,0 -> 0,0,0,1.
